// File: rtl/except_ctrl.sv
// except_ctrl: arbitrates interrupts and MEM-stage exceptions, drives CP0 type, flush, redirect PC and stall merge.
// Optional macro EXCEPT_TIMER_INT_EN folds timer_int_i into IP7 before masking.
module except_ctrl #(
    parameter logic [31:0] EXC_BASE     = 32'h00000020,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_address_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  stall_o,
    output logic        busy_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 2);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [7:0]  ip;
    logic        int_pend;
    logic        code_ok;
    logic        event_hit;
    logic [31:0] type_sel;
    logic [31:0] target;
    logic        unused_ok;

`ifdef EXCEPT_TIMER_INT_EN
    assign ip = {cause_i[15] | timer_int_i, cause_i[14:8]};
`else
    assign ip = cause_i[15:8];
`endif

    assign unused_ok = ^{timer_int_i, status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // A bubble (address 0) cannot take an interrupt: there is no instruction to restart.
    assign int_pend  = status_i[0] && !status_i[1] && |(ip & status_i[15:8]) && inst_addr_i != 32'd0;
    assign code_ok   = exc_code_i inside {5'd8, 5'd10, 5'd12, 5'd13, 5'd14};
    assign event_hit = int_pend || exc_valid_i;
    assign type_sel  = int_pend ? 32'h1 : {27'b0, code_ok ? exc_code_i : 5'd10};
    assign target    = type_sel == 32'd14 ? epc_i : EXC_BASE;

    always_comb begin
        stall_o = 6'b000000;
        if (state == IDLE)
            stall_o = stallreq_ex_i ? 6'b001111 : stallreq_id_i ? 6'b000111 : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= IDLE;
            cnt                    <= 4'd0;
            excepttype_o           <= 32'd0;
            current_inst_address_o <= 32'd0;
            is_in_delayslot_o      <= 1'b0;
            flush_o                <= 1'b0;
            new_pc_o               <= 32'd0;
            busy_o                 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_hit) begin
                        state                  <= COMMIT;
                        excepttype_o           <= type_sel;
                        current_inst_address_o <= inst_addr_i;
                        is_in_delayslot_o      <= in_delayslot_i;
                        flush_o                <= 1'b1;
                        new_pc_o               <= target;
                        busy_o                 <= 1'b1;
                    end
                end
                COMMIT: begin
                    excepttype_o <= 32'd0;
                    if (FLUSH_CYCLES == 1) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        state <= FLUSH;
                        cnt   <= CNT_INIT;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    flush_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_except_ctrl.sv
// tb_except_ctrl: vector table, hand-written corner sequences and randomized run against a cycle model.
module tb_except_ctrl;
    localparam int          FC   = 2;
    localparam logic [31:0] BASE = 32'h20;
`ifdef EXCEPT_TIMER_INT_EN
    localparam logic [31:0] TMR_T = 32'h1;
`else
    localparam logic [31:0] TMR_T = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id_i, stallreq_ex_i, exc_valid_i, in_delayslot_i, timer_int_i;
    logic [4:0]  exc_code_i;
    logic [31:0] inst_addr_i, status_i, cause_i, epc_i;
    logic [31:0] excepttype_o, current_inst_address_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, busy_o;
    logic [5:0]  stall_o;

    int n_cmp = 0;
    int n_bad = 0;

    except_ctrl #(.EXC_BASE(BASE), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
        .inst_addr_i(inst_addr_i), .in_delayslot_i(in_delayslot_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .timer_int_i(timer_int_i),
        .excepttype_o(excepttype_o), .current_inst_address_o(current_inst_address_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .stall_o(stall_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] status;
        logic [31:0] cause;
        logic        timer;
        logic        valid;
        logic [4:0]  code;
        logic [31:0] addr;
        logic        ds;
        logic [31:0] epc;
        logic [31:0] exp_type;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        stallreq_id_i = 0; stallreq_ex_i = 0; exc_valid_i = 0; exc_code_i = 0;
        inst_addr_i = 0; in_delayslot_i = 0; status_i = 0; cause_i = 0; epc_i = 0; timer_int_i = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] ref_type(input logic [31:0] st, input logic [31:0] ca, input logic tm,
                                             input logic v, input logic [4:0] code, input logic [31:0] addr);
        logic [7:0] ip;
        ip = ca[15:8];
`ifdef EXCEPT_TIMER_INT_EN
        if (tm) ip[7] = 1'b1;
`endif
        if (st[0] && !st[1] && (ip & st[15:8]) != 0 && addr != 0) return 32'h1;
        if (!v) return 32'h0;
        if (code == 8 || code == 10 || code == 12 || code == 13 || code == 14) return {27'b0, code};
        return 32'ha;
    endfunction

    vec_t vt[$];

    initial begin
        logic [31:0] m_type, m_addr, m_pc, et;
        logic        m_ds;
        int          rem, ecnt;
        logic [5:0]  m_stall;
        vt.push_back('{"syscall",  32'h0,        32'h0,     0, 1, 5'd8,  32'h100, 0, 32'h0,   32'h8, BASE});
        vt.push_back('{"eret",     32'h0,        32'h0,     0, 1, 5'd14, 32'h200, 0, 32'h3c0, 32'he, 32'h3c0});
        vt.push_back('{"int_win",  32'h00000401, 32'h0400,  0, 1, 5'd12, 32'h300, 1, 32'h0,   32'h1, BASE});
        vt.push_back('{"exl_ov",   32'h00000403, 32'h0400,  0, 1, 5'd12, 32'h304, 0, 32'h0,   32'hc, BASE});
        vt.push_back('{"timer",    32'h00008001, 32'h0,     1, 0, 5'd0,  32'h400, 0, 32'h0,   TMR_T, BASE});
        vt.push_back('{"bad_code", 32'h0,        32'h0,     0, 1, 5'd3,  32'h500, 1, 32'h0,   32'ha, BASE});
        vt.push_back('{"bubble",   32'h00000401, 32'h0400,  0, 0, 5'd0,  32'h0,   0, 32'h0,   32'h0, BASE});
        vt.push_back('{"ie_off",   32'h00000400, 32'h0400,  0, 0, 5'd0,  32'h600, 0, 32'h0,   32'h0, BASE});
        vt.push_back('{"trap_ds",  32'h0,        32'h0,     0, 1, 5'd13, 32'h700, 1, 32'h0,   32'hd, BASE});
        vt.push_back('{"masked",   32'h00000801, 32'h0400,  0, 0, 5'd0,  32'h800, 0, 32'h0,   32'h0, BASE});

        clear_in();
        rst = 0;
        #1;
        chk("rst_type", excepttype_o, 0);
        chk("rst_addr", current_inst_address_o, 0);
        chk("rst_ds", {31'b0, is_in_delayslot_o}, 0);
        chk("rst_flush", {31'b0, flush_o}, 0);
        chk("rst_pc", new_pc_o, 0);
        chk("rst_stall", {26'b0, stall_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        tick(); rst = 1; tick();

        foreach (vt[i]) begin
            status_i = vt[i].status; cause_i = vt[i].cause; timer_int_i = vt[i].timer;
            exc_valid_i = vt[i].valid; exc_code_i = vt[i].code; inst_addr_i = vt[i].addr;
            in_delayslot_i = vt[i].ds; epc_i = vt[i].epc;
            tick();
            clear_in();
            chk({vt[i].name, "_type"}, excepttype_o, vt[i].exp_type);
            chk({vt[i].name, "_flush"}, {31'b0, flush_o}, {31'b0, vt[i].exp_type != 0});
            if (vt[i].exp_type != 0) begin
                chk({vt[i].name, "_pc"}, new_pc_o, vt[i].exp_pc);
                chk({vt[i].name, "_addr"}, current_inst_address_o, vt[i].addr);
                chk({vt[i].name, "_ds"}, {31'b0, is_in_delayslot_o}, {31'b0, vt[i].ds});
            end
            repeat (FC + 1) tick();
        end

        // flush length, stall merge and event ignored during FLUSH
        stallreq_id_i = 1; stallreq_ex_i = 1; #1;
        chk("stall_idle_both", {26'b0, stall_o}, 32'h0f);
        stallreq_ex_i = 0; #1;
        chk("stall_idle_id", {26'b0, stall_o}, 32'h07);
        stallreq_ex_i = 1;
        exc_valid_i = 1; exc_code_i = 8; inst_addr_i = 32'h900;
        tick();
        exc_valid_i = 0; #1;
        chk("stall_commit", {26'b0, stall_o}, 0);
        chk("busy_commit", {31'b0, busy_o}, 1);
        ecnt = 0;
        for (int c = 0; c < 20 && flush_o; c++) begin
            ecnt++;
            if (ecnt == FC) begin
                chk("stall_flush", {26'b0, stall_o}, 0);
                exc_valid_i = 1; exc_code_i = 12; inst_addr_i = 32'ha00;
            end
            tick();
            exc_valid_i = 0;
        end
        chk("flush_len", ecnt, FC);
        tick();
        chk("ignored_type", excepttype_o, 0);
        chk("ignored_flush", {31'b0, flush_o}, 0);
        chk("ignored_addr", current_inst_address_o, 32'h900);
        stallreq_id_i = 0; stallreq_ex_i = 0;

        // back-to-back: held event re-accepted every FC+1 cycles
        exc_valid_i = 1; exc_code_i = 8; inst_addr_i = 32'hb00;
        for (int c = 0; c < 3 * (FC + 1); c++) begin
            tick();
            chk("b2b_type", excepttype_o, (c % (FC + 1) == 0) ? 32'h8 : 32'h0);
        end
        clear_in();
        repeat (FC + 1) tick();

        // reset asserted during FLUSH
        exc_valid_i = 1; exc_code_i = 14; epc_i = 32'hc00; inst_addr_i = 32'hd00; in_delayslot_i = 1;
        tick();
        clear_in();
        tick();
        chk("pre_rst_flush", {31'b0, flush_o}, 1);
        @(negedge clk); rst = 0; #1;
        chk("mid_rst_flush", {31'b0, flush_o}, 0);
        chk("mid_rst_pc", new_pc_o, 0);
        chk("mid_rst_addr", current_inst_address_o, 0);
        chk("mid_rst_ds", {31'b0, is_in_delayslot_o}, 0);
        chk("mid_rst_busy", {31'b0, busy_o}, 0);
        @(negedge clk); rst = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_flush", {31'b0, flush_o}, 0);
        end

        // randomized run against a cycle-count model
        rst = 0; tick(); rst = 1;
        m_type = 0; m_addr = 0; m_pc = 0; m_ds = 0; rem = 0;
        for (int c = 0; c < 600; c++) begin
            stallreq_id_i = 1'($urandom); stallreq_ex_i = 1'($urandom);
            exc_valid_i = ($urandom_range(0, 5) == 0);
            exc_code_i = 5'($urandom_range(6, 15));
            inst_addr_i = ($urandom_range(0, 7) == 0) ? 32'h0 : {$urandom} & 32'hfffc;
            in_delayslot_i = 1'($urandom);
            status_i = {16'h0, 8'($urandom), 6'h0, 1'($urandom), ($urandom_range(0, 3) != 0)};
            cause_i = ($urandom_range(0, 5) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
            epc_i = $urandom;
            timer_int_i = ($urandom_range(0, 9) == 0);
            #1;
            m_stall = (rem != 0) ? 6'h0 : stallreq_ex_i ? 6'h0f : stallreq_id_i ? 6'h07 : 6'h0;
            chk("rnd_stall", {26'b0, stall_o}, {26'b0, m_stall});
            et = ref_type(status_i, cause_i, timer_int_i, exc_valid_i, exc_code_i, inst_addr_i);
            if (rem == 0 && et != 0) begin
                m_type = et; m_addr = inst_addr_i; m_ds = in_delayslot_i;
                m_pc = (et == 32'he) ? epc_i : BASE;
                rem = FC;
            end else begin
                m_type = 0;
                if (rem > 0) rem--;
            end
            tick();
            chk("rnd_type", excepttype_o, m_type);
            chk("rnd_flush", {31'b0, flush_o}, {31'b0, rem != 0});
            chk("rnd_busy", {31'b0, busy_o}, {31'b0, rem != 0});
            chk("rnd_addr", current_inst_address_o, m_addr);
            chk("rnd_ds", {31'b0, is_in_delayslot_o}, {31'b0, m_ds});
            if (rem != 0) chk("rnd_pc", new_pc_o, m_pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
